// File: rtl/rcc_dx_rst_seq_if.sv
// Domain reset sequencer bus: request/power/flag-clear inputs and reset/clock-enable/status outputs.
interface rcc_dx_rst_seq_if;
  logic dx_rst_req;
  logic dx_pwr_rdy;
  logic rmvf;
  logic dx_rst_n;
  logic dx_clk_en;
  logic dx_seq_busy;
  logic dx_rst_ack;
  logic rst_flag;

  modport master (
    output dx_rst_req, dx_pwr_rdy, rmvf,
    input  dx_rst_n, dx_clk_en, dx_seq_busy, dx_rst_ack, rst_flag
  );

  modport slave (
    input  dx_rst_req, dx_pwr_rdy, rmvf,
    output dx_rst_n, dx_clk_en, dx_seq_busy, dx_rst_ack, rst_flag
  );
endinterface

// File: rtl/rcc_dx_rst_seq.sv
// Per-domain reset sequencer: gate clock, hold reset, wait power, release reset, re-enable clock.
// Optional sticky reset flag enabled by macro RCC_DX_RST_FLAG_EN (otherwise rst_flag is tied low).
module rcc_dx_rst_seq #(
  parameter int unsigned RST_DURATION = 10,
  parameter int unsigned CLK_ON_DELAY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rcc_dx_rst_seq_if.slave   io_dx
);

  localparam int unsigned CNT_MAX = (RST_DURATION > CLK_ON_DELAY) ? RST_DURATION : CLK_ON_DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_DURATION - 1);
  localparam logic [CNT_W-1:0] CLK_LOAD = CNT_W'((CLK_ON_DELAY == 0) ? 0 : CLK_ON_DELAY - 1);

  typedef enum logic [2:0] {
    ST_GATE,
    ST_ASSERT,
    ST_WAIT_PWR,
    ST_RELEASE,
    ST_RUN
  } state_t;

  // With no clock-on delay the hold phase skips RELEASE entirely.
  localparam state_t ST_AFTER_HOLD = (CLK_ON_DELAY == 0) ? ST_RUN : ST_RELEASE;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rst_n;
  logic             r_clk_en;
  logic             r_busy;
  logic             r_ack;
  logic             w_rst_n_nxt;
  logic             w_clk_en_nxt;
  logic             w_busy_nxt;
  logic             w_ack_nxt;
  logic             w_enter_assert;
  logic             w_pwr_ok;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ASSERT;
      r_cnt    <= RST_LOAD;
      r_rst_n  <= 1'b0;
      r_clk_en <= 1'b0;
      r_busy   <= 1'b1;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_clk_en <= w_clk_en_nxt;
      r_busy   <= w_busy_nxt;
      r_ack    <= w_ack_nxt;
    end
  end

  // Next state, counter and the outputs that go with the next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pwr_ok    = io_dx.dx_pwr_rdy && !io_dx.dx_rst_req;

    case (r_state)
      ST_RUN: begin
        if (io_dx.dx_rst_req) begin
          w_state_nxt = ST_GATE;
        end
      end
      ST_GATE: begin
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = RST_LOAD;
      end
      ST_ASSERT: begin
        if (r_cnt == '0) begin
          if (w_pwr_ok) begin
            w_state_nxt = ST_AFTER_HOLD;
            w_cnt_nxt   = CLK_LOAD;
          end else begin
            w_state_nxt = ST_WAIT_PWR;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_WAIT_PWR: begin
        if (w_pwr_ok) begin
          w_state_nxt = ST_AFTER_HOLD;
          w_cnt_nxt   = CLK_LOAD;
        end
      end
      ST_RELEASE: begin
        // Clock is already off, so a new request goes straight back to ASSERT.
        if (io_dx.dx_rst_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = RST_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = RST_LOAD;
      end
    endcase

    w_rst_n_nxt    = !((w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_WAIT_PWR));
    w_clk_en_nxt   = (w_state_nxt == ST_RUN);
    w_busy_nxt     = (w_state_nxt != ST_RUN);
    w_ack_nxt      = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
    w_enter_assert = (w_state_nxt == ST_ASSERT) && (r_state != ST_ASSERT);
  end

  assign io_dx.dx_rst_n    = r_rst_n;
  assign io_dx.dx_clk_en   = r_clk_en;
  assign io_dx.dx_seq_busy = r_busy;
  assign io_dx.dx_rst_ack  = r_ack;

`ifdef RCC_DX_RST_FLAG_EN
  logic r_flag;

  // Sticky flag: set on ASSERT entry, which wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b1;
    end else if (w_enter_assert) begin
      r_flag <= 1'b1;
    end else if (io_dx.rmvf) begin
      r_flag <= 1'b0;
    end
  end

  assign io_dx.rst_flag = r_flag;
`else
  logic w_unused_flag;

  assign w_unused_flag  = ^{io_dx.rmvf, w_enter_assert};
  assign io_dx.rst_flag = 1'b0;
`endif

endmodule

// File: tb/tb_rcc_dx_rst_seq.sv
// Bench for rcc_dx_rst_seq: directed timing checks plus random stimulus on two parameter sets,
// every cycle compared against a phase/elapsed-time model of the sequence.
module tb_rcc_dx_rst_seq;

`ifdef RCC_DX_RST_FLAG_EN
  localparam bit FLAG_ON = 1'b1;
`else
  localparam bit FLAG_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic req;
  logic pwr;
  logic rmvf;

  int n_chk = 0;
  int n_err = 0;

  rcc_dx_rst_seq_if if0 ();
  rcc_dx_rst_seq_if if1 ();

  assign if0.dx_rst_req = req;
  assign if0.dx_pwr_rdy = pwr;
  assign if0.rmvf       = rmvf;
  assign if1.dx_rst_req = req;
  assign if1.dx_pwr_rdy = pwr;
  assign if1.rmvf       = rmvf;

  rcc_dx_rst_seq #(.RST_DURATION(10), .CLK_ON_DELAY(8)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .io_dx (if0)
  );

  rcc_dx_rst_seq #(.RST_DURATION(1), .CLK_ON_DELAY(0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .io_dx (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: outputs plus "gating" flag and cycles elapsed in the current reset/delay phase.
  typedef struct {
    bit rst_n;
    bit clk_en;
    bit ack;
    bit flag;
    bit gating;
    int elapsed;
  } mdl_t;

  mdl_t m0;
  mdl_t m1;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.rst_n   = 1'b0;
    r.clk_en  = 1'b0;
    r.ack     = 1'b0;
    r.flag    = FLAG_ON;
    r.gating  = 1'b0;
    r.elapsed = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, int rd, int cd, bit rq, bit pw, bit rm);
    mdl_t n;
    int   e;
    bit   ent;
    n     = m;
    n.ack = 1'b0;
    ent   = 1'b0;
    if (m.clk_en) begin
      if (rq) begin
        n.clk_en = 1'b0;
        n.gating = 1'b1;
      end
    end else if (m.gating) begin
      n.gating  = 1'b0;
      n.rst_n   = 1'b0;
      n.elapsed = 0;
      ent       = 1'b1;
    end else if (!m.rst_n) begin
      e = m.elapsed + 1;
      if (e >= rd && pw && !rq) begin
        n.rst_n   = 1'b1;
        n.elapsed = 0;
        if (cd == 0) begin
          n.clk_en = 1'b1;
          n.ack    = 1'b1;
        end
      end else begin
        n.elapsed = (e > rd) ? rd : e;
      end
    end else begin
      if (rq) begin
        n.rst_n   = 1'b0;
        n.elapsed = 0;
        ent       = 1'b1;
      end else if (m.elapsed + 1 >= cd) begin
        n.clk_en = 1'b1;
        n.ack    = 1'b1;
      end else begin
        n.elapsed = m.elapsed + 1;
      end
    end
    if (!FLAG_ON)  n.flag = 1'b0;
    else if (ent)  n.flag = 1'b1;
    else if (rm)   n.flag = 1'b0;
    return n;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("d0_rst_n",  if0.dx_rst_n,    m0.rst_n);
    check("d0_clk_en", if0.dx_clk_en,   m0.clk_en);
    check("d0_busy",   if0.dx_seq_busy, !m0.clk_en);
    check("d0_ack",    if0.dx_rst_ack,  m0.ack);
    check("d0_flag",   if0.rst_flag,    m0.flag);
    check("d1_rst_n",  if1.dx_rst_n,    m1.rst_n);
    check("d1_clk_en", if1.dx_clk_en,   m1.clk_en);
    check("d1_busy",   if1.dx_seq_busy, !m1.clk_en);
    check("d1_ack",    if1.dx_rst_ack,  m1.ack);
    check("d1_flag",   if1.rst_flag,    m1.flag);
  endtask

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      m0 = step(m0, 10, 8, req, pwr, rmvf);
      m1 = step(m1, 1, 0, req, pwr, rmvf);
    end else begin
      m0 = mdl_reset();
      m1 = mdl_reset();
    end
    @(negedge clk);
    cmp_all();
  endtask

  task automatic async_rst(input int hold);
    #2 rst_n = 1'b0;
    #1;
    m0 = mdl_reset();
    m1 = mdl_reset();
    cmp_all();
    repeat (hold) cycle();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_run(input string name);
    int k;
    k = 0;
    while (!if0.dx_clk_en && k < 200) begin
      cycle();
      k++;
    end
    check(name, if0.dx_clk_en, 1'b1);
  endtask

  initial begin
    int rise_rst, rise_clk, fall_rst, acks, seen_clk, req_left;
    bit was_low;
    rst_n = 1'b0;
    req   = 1'b0;
    pwr   = 1'b1;
    rmvf  = 1'b0;
    m0    = mdl_reset();
    m1    = mdl_reset();

    // Power-on
    repeat (3) cycle();
    check("por_rst_n", if0.dx_rst_n, 1'b0);
    check("por_busy",  if0.dx_seq_busy, 1'b1);
    check("por_flag",  if0.rst_flag, FLAG_ON);
    #2 rst_n = 1'b1;
    rise_rst = 0; rise_clk = 0; acks = 0;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      if (rise_rst == 0 && if0.dx_rst_n)  rise_rst = k;
      if (rise_clk == 0 && if0.dx_clk_en) rise_clk = k;
      if (if0.dx_rst_ack) acks++;
      if (k == 17) check("por_busy_17", if0.dx_seq_busy, 1'b1);
      if (k == 18) check("por_busy_18", if0.dx_seq_busy, 1'b0);
    end
    check_int("por_rst_rise", rise_rst, 10);
    check_int("por_clk_rise", rise_clk, 18);
    check_int("por_acks", acks, 1);

    // Late power
    pwr = 1'b0;
    async_rst(2);
    rise_rst = 0; rise_clk = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 30) pwr = 1'b1;
      cycle();
      if (rise_rst == 0 && if0.dx_rst_n)  rise_rst = k;
      if (rise_clk == 0 && if0.dx_clk_en) rise_clk = k;
    end
    check_int("late_rst_rise", rise_rst, 30);
    check_int("late_clk_rise", rise_clk, 38);

    // Request in RUN
    req = 1'b1;
    cycle();
    req = 1'b0;
    check("rr_clk_fall", if0.dx_clk_en, 1'b0);
    check("rr_gate_rst", if0.dx_rst_n, 1'b1);
    fall_rst = 0; rise_rst = 0; rise_clk = 0; acks = 0;
    for (int k = 2; k <= 40; k++) begin
      cycle();
      if (fall_rst == 0 && !if0.dx_rst_n) fall_rst = k;
      if (fall_rst != 0 && rise_rst == 0 && if0.dx_rst_n) rise_rst = k;
      if (rise_clk == 0 && if0.dx_clk_en) rise_clk = k;
      if (if0.dx_rst_ack) acks++;
    end
    check_int("rr_rst_fall", fall_rst, 2);
    check_int("rr_low_len", rise_rst - fall_rst, 10);
    check_int("rr_clk_delay", rise_clk - rise_rst, 8);
    check_int("rr_acks", acks, 1);

    // Request in RELEASE
    req = 1'b1;
    cycle();
    req = 1'b0;
    was_low = 1'b0;
    for (int k = 0; k < 60 && !(was_low && if0.dx_rst_n); k++) begin
      cycle();
      if (!if0.dx_rst_n) was_low = 1'b1;
    end
    check("rel_rise_seen", if0.dx_rst_n, 1'b1);
    repeat (2) cycle();
    req = 1'b1;
    cycle();
    req = 1'b0;
    check("rel_rst_fall", if0.dx_rst_n, 1'b0);
    rise_rst = 0; seen_clk = 0;
    for (int k = 1; k <= 30 && rise_rst == 0; k++) begin
      cycle();
      if (if0.dx_clk_en) seen_clk++;
      if (if0.dx_rst_n) rise_rst = k;
    end
    check_int("rel_low_len", rise_rst, 10);
    check_int("rel_no_clk", seen_clk, 0);

    // Asynchronous reset five cycles into ASSERT
    wait_run("ar_run");
    req = 1'b1;
    cycle();
    req = 1'b0;
    for (int k = 0; k < 10 && if0.dx_rst_n; k++) cycle();
    check("ar_in_assert", if0.dx_rst_n, 1'b0);
    repeat (5) cycle();
    async_rst(1);
    check("ar_clk_en", if0.dx_clk_en, 1'b0);
    check("ar_rst_n",  if0.dx_rst_n,  1'b0);
    check("ar_busy",   if0.dx_seq_busy, 1'b1);
    check("ar_flag",   if0.rst_flag, FLAG_ON);
    rise_rst = 0;
    for (int k = 1; k <= 30 && rise_rst == 0; k++) begin
      cycle();
      if (if0.dx_rst_n) rise_rst = k;
    end
    check_int("ar_full_assert", rise_rst, 10);

    // Flag clear in RUN, and clear coincident with ASSERT entry
    wait_run("fl_run");
    rmvf = 1'b1;
    cycle();
    rmvf = 1'b0;
    check("fl_clear", if0.rst_flag, 1'b0);
    req = 1'b1;
    cycle();
    req  = 1'b0;
    rmvf = 1'b1;
    cycle();
    rmvf = 1'b0;
    check("fl_set_wins", if0.rst_flag, FLAG_ON);

    // Random traffic, including mid-sequence async resets
    req_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (req_left > 0) begin
        req = 1'b1;
        req_left--;
      end else begin
        req = 1'b0;
        if ($urandom_range(0, 24) == 0) req_left = int'($urandom_range(1, 5));
      end
      pwr  = ($urandom_range(0, 5) != 0);
      rmvf = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) async_rst(int'($urandom_range(1, 3)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
